// File: rtl/conv_ram_seq.sv
// Sequencer for the convolution pixel SRAM: LOAD writes a pixel stream to consecutive addresses,
// READ streams the words back through a 2-entry buffer that absorbs read latency and backpressure.
module conv_ram_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  load_start,
  input  logic                  read_start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t                state_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         wcnt_q;
  logic [CW-1:0]         rcnt_q;
  logic [CW-1:0]         ocnt_q;
  logic                  done_q;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];

  logic [CW-1:0]         len_d;
  logic [1:0]            count_d;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  pop;
  logic                  pop_stored;
  logic                  push;
  logic [DATA_WIDTH-1:0] head;

  assign len_d = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign in_ready = (state_q == LOAD) && (wcnt_q < len_q);
  assign wr_fire  = in_valid && in_ready;

  // Credit: a read is only issued if its word is guaranteed a buffer slot.
  assign rd_issue = (state_q == READ) && (rcnt_q < len_q) &&
                    (({1'b0, inflight_q} + count_q) < 2'd2);

  // A word returning from the SRAM is visible at the output in its arrival cycle,
  // which keeps the first-pixel latency at two cycles and the stream gap-free.
  assign out_valid  = (count_q != 2'd0) || inflight_q;
  assign head       = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : ram_rdata;
  assign out_data   = out_valid ? head : '0;
  assign out_last   = out_valid && (ocnt_q == len_q - ONE_C);
  assign pop        = out_valid && out_ready;
  assign pop_stored = pop && (count_q != 2'd0);
  assign push       = inflight_q && !(pop && (count_q == 2'd0));

  always_comb begin
    count_d = count_q;
    if (push && !pop_stored) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop_stored) begin
      count_d = count_q - 2'd1;
    end
  end

  assign ram_write_en = wr_fire;
  assign ram_read_en  = rd_issue;
  assign ram_addr     = wr_fire  ? wcnt_q[ADDR_WIDTH-1:0] :
                        rd_issue ? rcnt_q[ADDR_WIDTH-1:0] : addr_q;
  assign ram_wdata    = wr_fire ? in_data : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_issue;
      count_q    <= count_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_stored) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (wr_fire || rd_issue) begin
        addr_q <= ram_addr;
      end
      if (wr_fire) begin
        wdata_q <= in_data;
      end

      case (state_q)
        IDLE: begin
          if (load_start || read_start) begin
            len_q  <= len_d;
            wcnt_q <= '0;
            rcnt_q <= '0;
            ocnt_q <= '0;
            if (len_d == '0) begin
              done_q <= 1'b1;
            end else if (load_start) begin
              state_q <= LOAD;
            end else begin
              state_q <= READ;
            end
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wcnt_q <= wcnt_q + ONE_C;
            if (wcnt_q == len_q - ONE_C) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            rcnt_q <= rcnt_q + ONE_C;
          end
          if (pop) begin
            ocnt_q <= ocnt_q + ONE_C;
          end
          if (pop && out_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer storage is pure data; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_conv_ram_seq.sv
// Directed bench for conv_ram_seq: a vector table for the short LOAD/READ phases plus
// hand-written sequences for the 1024-word clamp and the mid-READ reset.
module tb_conv_ram_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] cfg_len = '0;
  logic        load_start = 1'b0;
  logic        read_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        busy, done, in_ready, out_valid, out_last;
  logic [7:0]  out_data, ram_wdata;
  logic        ram_write_en, ram_read_en;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_rdata = '0;

  conv_ram_seq dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .load_start(load_start), .read_start(read_start),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 1024x8, one-cycle read latency.
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_wdata;
    if (ram_read_en)  ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, done_cnt = 0;
  int outst = 0, max_outst = 0;

  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
    end else begin
      if (ram_write_en) we_cnt++;
      if (ram_read_en) re_cnt++;
      if (ram_write_en && ram_read_en) both_cnt++;
      if (done) done_cnt++;
      if (ram_read_en) outst++;
      if (out_valid && out_ready) outst--;
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] ramp(input int i);
    return 8'((i * 7 + 90) ^ (i >> 8));
  endfunction

  typedef struct {
    logic       ls, rs;
    logic [10:0] len;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic [4:0] flags;   // busy, done, in_ready, ram_write_en, ram_read_en
    logic [9:0] addr;
    logic [7:0] wd;      // compared only when a write is expected
    logic       ov;
    logic [7:0] od;      // compared only when out_valid is expected
    logic       ol;
  } vec_t;

  localparam int NV = 29;
  vec_t vec [NV];

  function automatic vec_t mk(input logic ls, input logic rs, input logic [10:0] len,
                              input logic iv, input logic [7:0] id, input logic ordy,
                              input logic [4:0] flags, input logic [9:0] addr,
                              input logic [7:0] wd, input logic ov, input logic [7:0] od,
                              input logic ol);
    vec_t v;
    v.ls = ls; v.rs = rs; v.len = len; v.iv = iv; v.id = id; v.ordy = ordy;
    v.flags = flags; v.addr = addr; v.wd = wd; v.ov = ov; v.od = od; v.ol = ol;
    return v;
  endfunction

  function automatic logic [32:0] outs_now();
    return {busy, done, in_ready, ram_write_en, ram_read_en, ram_addr, ram_wdata,
            out_valid, out_data, out_last};
  endfunction

  task automatic run_rows(input int lo, input int hi);
    logic [32:0] act, exp;
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk); #1;
      load_start = vec[i].ls; read_start = vec[i].rs; cfg_len = vec[i].len;
      in_valid = vec[i].iv; in_data = vec[i].id; out_ready = vec[i].ordy;
      @(negedge clk);
      act = outs_now();
      if (!vec[i].flags[1]) act[17:10] = vec[i].wd;
      if (!vec[i].ov) act[8:1] = vec[i].od;
      exp = {vec[i].flags, vec[i].addr, vec[i].wd, vec[i].ov, vec[i].od, vec[i].ol};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL row%0d: got flags=%b addr=%0h wdata=%h ov=%b od=%h last=%b, expected flags=%b addr=%0h wdata=%h ov=%b od=%h last=%b",
                 i, act[32:28], act[27:18], act[17:10], act[9], act[8:1], act[0],
                 exp[32:28], exp[27:18], exp[17:10], exp[9], exp[8:1], exp[0]);
      end else begin
        $display("ok   row%0d: flags=%b addr=%0h ov=%b od=%h last=%b",
                 i, act[32:28], act[27:18], act[9], act[8:1], act[0]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, rd_idx, bad, first_it, done_it, n, done_snap;
    logic [7:0] pix [4];
    logic [3:0] lastf;

    // len=0 start, then LOAD of 4 pixels with a bubble (read_start during LOAD is ignored)
    vec[0]  = mk(1,0,0, 0,8'h00,0, 5'b00000, 0,8'h00, 0,8'h00,0);
    vec[1]  = mk(0,0,0, 0,8'h00,0, 5'b01000, 0,8'h00, 0,8'h00,0);
    vec[2]  = mk(0,0,0, 0,8'h00,0, 5'b00000, 0,8'h00, 0,8'h00,0);
    vec[3]  = mk(1,0,4, 0,8'h00,0, 5'b00000, 0,8'h00, 0,8'h00,0);
    vec[4]  = mk(0,0,4, 1,8'h11,0, 5'b10110, 0,8'h11, 0,8'h00,0);
    vec[5]  = mk(0,1,4, 0,8'h22,0, 5'b10100, 0,8'h00, 0,8'h00,0);
    vec[6]  = mk(0,0,4, 1,8'h22,0, 5'b10110, 1,8'h22, 0,8'h00,0);
    vec[7]  = mk(0,0,4, 1,8'h33,0, 5'b10110, 2,8'h33, 0,8'h00,0);
    vec[8]  = mk(0,0,4, 1,8'h44,0, 5'b10110, 3,8'h44, 0,8'h00,0);
    vec[9]  = mk(0,0,4, 0,8'h00,0, 5'b01000, 3,8'h00, 0,8'h00,0);
    vec[10] = mk(0,0,4, 0,8'h00,0, 5'b00000, 3,8'h00, 0,8'h00,0);
    // READ len=4 at full rate
    vec[11] = mk(0,1,4, 0,8'h00,1, 5'b00000, 3,8'h00, 0,8'h00,0);
    vec[12] = mk(0,0,4, 0,8'h00,1, 5'b10001, 0,8'h00, 0,8'h00,0);
    vec[13] = mk(0,0,4, 0,8'h00,1, 5'b10001, 1,8'h00, 1,8'h11,0);
    vec[14] = mk(0,0,4, 0,8'h00,1, 5'b10001, 2,8'h00, 1,8'h22,0);
    vec[15] = mk(0,0,4, 0,8'h00,1, 5'b10001, 3,8'h00, 1,8'h33,0);
    vec[16] = mk(0,0,4, 0,8'h00,1, 5'b10000, 3,8'h00, 1,8'h44,1);
    vec[17] = mk(0,0,4, 0,8'h00,1, 5'b01000, 3,8'h00, 0,8'h00,0);
    vec[18] = mk(0,0,4, 0,8'h00,1, 5'b00000, 3,8'h00, 0,8'h00,0);
    // READ len=4 with out_ready 1,0,0,1,0,1,1 from the first valid cycle
    vec[19] = mk(0,1,4, 0,8'h00,1, 5'b00000, 3,8'h00, 0,8'h00,0);
    vec[20] = mk(0,0,4, 0,8'h00,1, 5'b10001, 0,8'h00, 0,8'h00,0);
    vec[21] = mk(0,0,4, 0,8'h00,1, 5'b10001, 1,8'h00, 1,8'h11,0);
    vec[22] = mk(0,0,4, 0,8'h00,0, 5'b10001, 2,8'h00, 1,8'h22,0);
    vec[23] = mk(0,0,4, 0,8'h00,0, 5'b10000, 2,8'h00, 1,8'h22,0);
    vec[24] = mk(0,0,4, 0,8'h00,1, 5'b10000, 2,8'h00, 1,8'h22,0);
    vec[25] = mk(0,0,4, 0,8'h00,0, 5'b10001, 3,8'h00, 1,8'h33,0);
    vec[26] = mk(0,0,4, 0,8'h00,1, 5'b10000, 3,8'h00, 1,8'h33,0);
    vec[27] = mk(0,0,4, 0,8'h00,1, 5'b10000, 3,8'h00, 1,8'h44,1);
    vec[28] = mk(0,0,4, 0,8'h00,0, 5'b01000, 3,8'h00, 0,8'h00,0);

    @(negedge clk);
    check("reset_outputs", 32'(outs_now()), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_rows(0, 2);
    #1;
    check("len0_no_ram_access", 32'(we_cnt + re_cnt), 32'd0);
    run_rows(3, 28);
    #1;
    checks++;
    if (max_outst > 2) begin
      failures++;
      $display("FAIL max_outstanding: got %0d, required at most 2", max_outst);
    end else begin
      $display("ok   max_outstanding: %0d", max_outst);
    end

    // cfg_len=1500 LOAD with both starts high: load wins, clamp to 1024 writes
    @(posedge clk); #1;
    load_start = 1'b1; read_start = 1'b1; cfg_len = 11'd1500; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0; read_start = 1'b0; in_valid = 1'b1; in_data = ramp(0);
    idx = 0; bad = 0; done_it = -1;
    for (int it = 0; it < 1100; it++) begin
      @(negedge clk);
      if (it == 0) check("load_wins_in_ready", 32'(in_ready), 32'd1);
      if (ram_write_en) begin
        if (ram_addr != 10'(idx) || ram_wdata != ramp(idx)) bad++;
        idx++;
      end
      if (done) begin
        done_it = it;
        check("load_done_in_ready", 32'(in_ready), 32'd0);
        break;
      end
      @(posedge clk); #1 in_data = ramp(idx);
    end
    check("load_clamp_writes", 32'(idx), 32'd1024);
    check("load_addr_data_errors", 32'(bad), 32'd0);
    check("load_done_cycle", 32'(done_it), 32'd1024);

    @(posedge clk); #1;
    in_valid = 1'b0; read_start = 1'b1; cfg_len = 11'd1500; out_ready = 1'b1;
    @(posedge clk); #1 read_start = 1'b0;
    idx = 0; rd_idx = 0; bad = 0; first_it = -1; done_it = -1;
    for (int it = 0; it < 1100; it++) begin
      @(negedge clk);
      if (ram_read_en) begin
        if (ram_addr != 10'(rd_idx)) bad++;
        rd_idx++;
      end
      if (out_valid) begin
        if (first_it < 0) first_it = it;
        if (out_data != ramp(idx)) bad++;
        if (out_last != (idx == 1023)) bad++;
        idx++;
      end
      if (done) begin
        done_it = it;
        break;
      end
    end
    check("read1024_first_valid", 32'(first_it), 32'd1);
    check("read1024_pixels", 32'(idx), 32'd1024);
    check("read1024_reads", 32'(rd_idx), 32'd1024);
    check("read1024_errors", 32'(bad), 32'd0);
    check("read1024_done_cycle", 32'(done_it), 32'd1025);

    // reset in the middle of a READ after 3 accepted pixels
    @(posedge clk); #1;
    read_start = 1'b1; cfg_len = 11'd4; out_ready = 1'b1;
    @(posedge clk); #1 read_start = 1'b0;
    n = 0;
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      if (n == 3) break;
    end
    check("pre_rst_pixels", 32'(n), 32'd3);
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    done_snap = done_cnt;
    rst = 1'b1; #1;
    check("rst_mid_read_outputs", 32'(outs_now()), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'(done_snap));

    @(posedge clk); #1;
    read_start = 1'b1; cfg_len = 11'd2; out_ready = 1'b1;
    @(posedge clk); #1 read_start = 1'b0;
    n = 0; lastf = '0; done_it = -1;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      if (out_valid && out_ready && n < 4) begin
        pix[n] = out_data; lastf[n] = out_last; n++;
      end
      if (done) begin
        done_it = it;
        break;
      end
    end
    check("post_rst_pixels", 32'(n), 32'd2);
    check("post_rst_word0", 32'(pix[0]), 32'(ramp(0)));
    check("post_rst_word1", 32'(pix[1]), 32'(ramp(1)));
    check("post_rst_last", 32'(lastf[1:0]), 32'd2);
    check("post_rst_done_cycle", 32'(done_it), 32'd3);
    check("never_both_enables", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_ram_seq.md
Name: conv_ram_seq

Overview:
- Sequencer directly upstream of the convolution 1024x8 single-port SRAM wrapper; sole driver of its write enable, read enable, address and write data.
- LOAD phase: accepts a pixel stream over valid/ready and writes it to consecutive SRAM addresses.
- READ phase: streams the same pixels back to the convolution datapath over valid/ready.
- Hides the 1-cycle SRAM read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- ADDR_WIDTH, 10, SRAM address width (from conv_defines_pkg).
- DATA_WIDTH, 8, pixel width (from conv_defines_pkg).
- DEPTH, 1024, number of SRAM words; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  ADDR_WIDTH+1  pixel count; sampled on an accepted start.
- load_start  in  1  single-cycle pulse: begin LOAD.
- read_start  in  1  single-cycle pulse: begin READ.
- busy  out  1  high in LOAD or READ.
- done  out  1  single-cycle pulse when a phase completes.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_data  out  DATA_WIDTH  output pixel.
- out_last  out  1  marks the final pixel of a READ.
- ram_write_en  out  1  to SRAM wrapper write_en.
- ram_read_en  out  1  to SRAM wrapper read_en.
- ram_addr  out  ADDR_WIDTH  to SRAM wrapper addr.
- ram_wdata  out  DATA_WIDTH  to SRAM wrapper ram_data_in.
- ram_rdata  in  DATA_WIDTH  from SRAM wrapper ram_data_out.

Behaviour:
- Reset: state IDLE, counters 0, buffer empty. busy, done, in_ready, out_valid, out_last, ram_write_en and ram_read_en are 0; ram_addr, ram_wdata and out_data are 0. SRAM contents are untouched.
- Reset mid-phase: abort immediately, return to IDLE, flush the buffer, do not pulse done.
- States: IDLE, LOAD, READ.
- Starting a phase:
  - Starts are accepted only in IDLE; starts while busy are ignored.
  - load_start and read_start together in IDLE: load wins.
  - len = min(cfg_len, DEPTH), latched on the accepted start.
  - len==0: stay in IDLE, pulse done the next cycle, no SRAM access.
  - busy rises the cycle after an accepted start.
- LOAD:
  - in_ready=1 combinationally while in LOAD with wcnt<len; address counter wcnt starts at 0.
  - On in_valid&&in_ready, in the same cycle: ram_write_en=1, ram_addr=wcnt, ram_wdata=in_data, then wcnt++.
  - After the len-th write: go to IDLE next cycle, done=1 for one cycle, in_ready=0.
- READ:
  - SRAM read latency is 1 cycle: ram_rdata is valid the cycle after ram_read_en.
  - Credit rule: issue ram_read_en (ram_addr=rcnt, rcnt++) only when rcnt<len and (reads in flight + buffer occupancy) < 2. The buffer therefore never overflows.
  - The returning ram_rdata is pushed into a 2-entry FIFO. out_valid = FIFO not empty; out_data = FIFO head.
  - Pop on out_valid&&out_ready. Simultaneous push and pop is allowed.
  - out_last=1 exactly when the head is pixel number len-1.
  - First out_valid appears 2 cycles after read_start is accepted.
  - With out_ready held at 1: sustained 1 pixel/cycle, len pixels in len+2 cycles from the start.
  - Phase ends when the pixel with out_last is accepted: done pulses the next cycle, state returns to IDLE.
  - out_data is held stable while out_valid&&!out_ready.
- SRAM drive:
  - ram_write_en and ram_read_en are never both 1.
  - Both are 0 in IDLE.
  - ram_addr is held at its last value when not accessing.
- Address wrap: len=DEPTH ends at address DEPTH-1. Counters are ADDR_WIDTH+1 bits wide, so there is no aliasing.

Test Plan:
- Reset then idle: all outputs 0; load_start with cfg_len=0 -> done pulse 1 cycle later, no ram_write_en/ram_read_en ever asserted.
- LOAD len=4 with in_data 0x11,0x22,0x33,0x44 and in_valid toggling 1,0,1,1,1 -> writes to addr 0..3 in order, in_ready drops after the 4th write, done pulses once.
- READ len=4, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles starting 2 cycles after the start; out_last only on 0x44; done the next cycle.
- READ len=4 with out_ready pattern 1,0,0,1,0,1,1 -> no pixel lost or duplicated, never more than 2 reads outstanding, out_data stable while stalled.
- cfg_len=1500 LOAD then READ of 1024 ramp values -> clamped to 1024, addresses 0..1023, read data matches the ramp.
- rst asserted mid-READ after 3 pixels -> outputs 0 immediately, no done pulse; a new READ len=2 returns SRAM words 0 and 1 correctly.
